// File: rtl/bpsk_tx_frame_ctrl.sv
// BPSK transmit frame sequencer: serialises preamble, sync word, length byte and
// payload onto the modem bit interface, holding each bit for SYM_CYCLES clocks.
module bpsk_tx_frame_ctrl #(
  parameter int unsigned SYM_CYCLES    = 20,
  parameter int unsigned PREAMBLE_BITS = 16,
  parameter logic [15:0] SYNC_WORD     = 16'hD391,
  parameter int unsigned GAP_BITS      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       bit_data,
  output logic       bit_en,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_SYNC, S_LEN, S_PAYLOAD, S_GAP
  } state_t;

  localparam int unsigned SYM_W     = $clog2(SYM_CYCLES);
  localparam int unsigned FIELD_MAX = (PREAMBLE_BITS > 16)
                                      ? ((PREAMBLE_BITS > GAP_BITS) ? PREAMBLE_BITS : GAP_BITS)
                                      : ((GAP_BITS > 16) ? GAP_BITS : 16);
  localparam int unsigned BIT_W     = $clog2(FIELD_MAX);

  state_t           state_q;
  logic [SYM_W-1:0] sym_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [7:0]       len_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic [14:0]      shift_q;
  logic [7:0]       acc_cnt_q;
  logic [7:0]       sent_cnt_q;
  logic             bit_data_q;
  logic             bit_en_q;
  logic             busy_q;
  logic             done_q;
  logic             underrun_q;

  logic bit_strobe;
  logic byte_boundary;
  logic handshake;
  logic underrun_d;

  assign bit_strobe = (sym_cnt_q == SYM_W'(SYM_CYCLES - 1));
  assign handshake  = s_valid && s_ready;

  // Last bit of a field after which a fresh payload byte must go on air.
  assign byte_boundary = (bit_cnt_q == BIT_W'(7)) &&
                         ((state_q == S_LEN) ||
                          ((state_q == S_PAYLOAD) && (sent_cnt_q != len_q)));

  // Looks one cycle ahead so the pulse lines up with the strobe cycle of the
  // boundary while still accounting for a byte accepted on the edge before it.
  assign underrun_d = byte_boundary && (sym_cnt_q == SYM_W'(SYM_CYCLES - 2)) &&
                      !hold_full_q && !handshake;

  assign s_ready  = ((state_q == S_SYNC) || (state_q == S_LEN) || (state_q == S_PAYLOAD)) &&
                    !hold_full_q && (acc_cnt_q < len_q);
  assign bit_data = bit_data_q;
  assign bit_en   = bit_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign underrun = underrun_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: hold_q payload is not reset; hold_full_q alone marks it valid.
      state_q     <= S_IDLE;
      sym_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      len_q       <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      acc_cnt_q   <= '0;
      sent_cnt_q  <= '0;
      bit_data_q  <= 1'b0;
      bit_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      underrun_q <= underrun_d;

      if (handshake) begin
        hold_q      <= s_data;
        hold_full_q <= 1'b1;
        acc_cnt_q   <= acc_cnt_q + 1'b1;
      end

      if (state_q != S_IDLE) begin
        sym_cnt_q <= bit_strobe ? '0 : sym_cnt_q + 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start && (frame_len != 8'd0)) begin
            state_q     <= S_PREAMBLE;
            len_q       <= frame_len;
            sym_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            acc_cnt_q   <= '0;
            sent_cnt_q  <= '0;
            hold_full_q <= 1'b0;
            bit_data_q  <= 1'b1;
            bit_en_q    <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        S_PREAMBLE: begin
          if (bit_strobe) begin
            if (bit_cnt_q == BIT_W'(PREAMBLE_BITS - 1)) begin
              state_q    <= S_SYNC;
              bit_cnt_q  <= '0;
              bit_data_q <= SYNC_WORD[15];
              shift_q    <= SYNC_WORD[14:0];
            end else begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              bit_data_q <= ~bit_data_q;
            end
          end
        end

        S_SYNC: begin
          if (bit_strobe) begin
            if (bit_cnt_q == BIT_W'(15)) begin
              state_q    <= S_LEN;
              bit_cnt_q  <= '0;
              bit_data_q <= len_q[7];
              shift_q    <= {len_q[6:0], 8'h00};
            end else begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              bit_data_q <= shift_q[14];
              shift_q    <= {shift_q[13:0], 1'b0};
            end
          end
        end

        S_LEN, S_PAYLOAD: begin
          if (bit_strobe) begin
            if (bit_cnt_q != BIT_W'(7)) begin
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              bit_data_q <= shift_q[14];
              shift_q    <= {shift_q[13:0], 1'b0};
            end else if (byte_boundary && hold_full_q) begin
              state_q     <= S_PAYLOAD;
              bit_cnt_q   <= '0;
              bit_data_q  <= hold_q[7];
              shift_q     <= {hold_q[6:0], 8'h00};
              hold_full_q <= 1'b0;
              sent_cnt_q  <= sent_cnt_q + 1'b1;
            end else begin
              // Frame complete, or underrun: either way the gap follows and
              // anything left in the holding register is dropped.
              state_q     <= S_GAP;
              bit_cnt_q   <= '0;
              bit_data_q  <= 1'b0;
              bit_en_q    <= 1'b0;
              hold_full_q <= 1'b0;
            end
          end
        end

        S_GAP: begin
          if (bit_strobe) begin
            if (bit_cnt_q == BIT_W'(GAP_BITS - 1)) begin
              state_q     <= S_IDLE;
              bit_cnt_q   <= '0;
              acc_cnt_q   <= '0;
              sent_cnt_q  <= '0;
              hold_full_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
